// File: rtl/stream_player.sv
// stream_player
// Plays back a stored word pattern as a valid/ready stream. A pattern memory
// is loaded while the player is idle; a start request then emits the first
// len words in order, either once or repeatedly until stop is raised.
//
// Ports
//   clk       sole clock, all state changes on the rising edge
//   rst       synchronous active-high reset (pattern memory is kept)
//   wr_en     pattern-memory write strobe (ignored while playing)
//   wr_addr   pattern-memory write address
//   wr_data   pattern-memory write data
//   start     begin playback, only honoured in IDLE with a legal len
//   stop      abort playback, only honoured in PLAY
//   len       words per pass, legal range 1..DEPTH, sampled with start
//   loop_en   repeat passes until stop, sampled with start
//   out_data  current word (0 when not playing)
//   out_valid out_data carries a word
//   out_ready consumer accepts the current word
//   busy      high while playing
//   done      one-cycle pulse after a finished pass or a stop
//   pass_cnt  completed passes since the last accepted start

module stream_player #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             start,
    input  logic             stop,
    input  logic [AW:0]      len,
    input  logic             loop_en,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             busy,
    output logic             done,
    output logic [15:0]      pass_cnt
);

    typedef enum logic [1:0] {
        IDLE,
        PLAY,
        FINISH
    } state_t;

    localparam logic [AW:0]   DEPTH_W = (AW + 1)'(DEPTH);
    localparam logic [AW:0]   LEN_ONE = (AW + 1)'(1);
    localparam logic [AW-1:0] PTR_ONE = AW'(1);

    state_t           state;
    state_t           state_next;
    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    ptr;
    logic [AW-1:0]    ptr_next;
    logic [AW:0]      len_q;
    logic [AW:0]      len_next;
    logic             loop_q;
    logic             loop_next;
    logic [15:0]      pass_q;
    logic [15:0]      pass_next;
    logic             len_ok;
    logic             last_word;

    // A start request is only meaningful when it asks for at least one word
    // and no more words than the memory holds; anything else is dropped.
    assign len_ok    = (len != '0) && (len <= DEPTH_W);
    assign last_word = ({1'b0, ptr} == (len_q - LEN_ONE));

    // Outputs are decoded purely from the registered state and pointer, so
    // a stalled consumer always sees a stable word.
    assign out_valid = (state == PLAY);
    assign busy      = (state == PLAY);
    assign done      = (state == FINISH);
    assign out_data  = (state == PLAY) ? mem[ptr] : '0;
    assign pass_cnt  = pass_q;

    // Next-state logic. Stop wins over a simultaneous transfer: the pointer
    // and pass count are left alone and the player goes straight to FINISH.
    // Only a handshake (valid and ready) advances the pointer; the last word
    // of a pass bumps the pass count and either rewinds or ends the pass.
    always_comb begin
        state_next = state;
        ptr_next   = ptr;
        len_next   = len_q;
        loop_next  = loop_q;
        pass_next  = pass_q;
        case (state)
            IDLE: begin
                if (start && len_ok) begin
                    state_next = PLAY;
                    ptr_next   = '0;
                    len_next   = len;
                    loop_next  = loop_en;
                    pass_next  = '0;
                end
            end
            PLAY: begin
                if (stop) begin
                    state_next = FINISH;
                end else if (out_ready) begin
                    if (last_word) begin
                        pass_next = pass_q + 16'd1;
                        if (loop_q) begin
                            ptr_next = '0;
                        end else begin
                            state_next = FINISH;
                        end
                    end else begin
                        ptr_next = ptr + PTR_ONE;
                    end
                end
            end
            FINISH: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // State and playback registers. Reset returns everything to a quiet IDLE
    // without producing a done pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            ptr    <= '0;
            len_q  <= '0;
            loop_q <= 1'b0;
            pass_q <= '0;
        end else begin
            state  <= state_next;
            ptr    <= ptr_next;
            len_q  <= len_next;
            loop_q <= loop_next;
            pass_q <= pass_next;
        end
    end

    // Pattern memory. Writes are locked out during playback so the word being
    // presented cannot change under the consumer, and a reset cycle blocks the
    // write, but reset never clears the stored pattern.
    always_ff @(posedge clk) begin
        if (!rst && wr_en && (state != PLAY)) begin
            mem[wr_addr] <= wr_data;
        end
    end

endmodule

// File: tb/tb_stream_player.sv
// tb_stream_player
// Self-checking bench for stream_player. Stimulus tasks push the words the
// consumer should receive into a scoreboard queue; an independent monitor on
// the falling edge pops and compares on every handshake. The reference model
// is just an array mirroring the pattern memory plus transfer counting.

module tb_stream_player;

    logic        clk;
    logic        rst;
    logic        wr_en;
    logic [3:0]  wr_addr;
    logic [15:0] wr_data;
    logic        start;
    logic        stop;
    logic [4:0]  len;
    logic        loop_en;
    logic [15:0] out_data;
    logic        out_valid;
    logic        out_ready;
    logic        busy;
    logic        done;
    logic [15:0] pass_cnt;

    logic [15:0] tb_mem [16];
    logic [15:0] exp_q [$];
    int          checks;
    int          errors;
    int          xfer_cnt;
    int          cur_len;

    stream_player #(
        .WIDTH (16),
        .DEPTH (16),
        .AW    (4)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .start     (start),
        .stop      (stop),
        .len       (len),
        .loop_en   (loop_en),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .busy      (busy),
        .done      (done),
        .pass_cnt  (pass_cnt)
    );

    // Free-running clock, 10 time units per period.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Hard time limit so a stuck design can never hang the run.
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog actual=timeout required=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [31:0] act,
                               input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Monitor: a handshake seen on the falling edge completes at the next
    // rising edge unless reset is pending. Every consumed word is compared,
    // but a word taken on the stop edge does not count toward a pass.
    always @(negedge clk) begin
        if (out_valid && out_ready && !rst) begin
            if (exp_q.size() == 0) begin
                checkOutput("queue_nonempty", 32'd0, 32'd1);
            end else begin
                checkOutput("word", {16'd0, out_data}, {16'd0, exp_q.pop_front()});
            end
            if (!stop) xfer_cnt++;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic writeWord(input int a, input logic [15:0] d);
        wr_en   = 1'b1;
        wr_addr = a[3:0];
        wr_data = d;
        tick();
        wr_en   = 1'b0;
        tb_mem[a] = d;
    endtask

    // Issue a legal start, queue the words the consumer should see, and
    // check the first word appears right after the start edge.
    task automatic applyStimulus(input int l, input logic lp);
        exp_q.delete();
        if (lp) begin
            for (int i = 0; i < 64; i++) exp_q.push_back(tb_mem[i % l]);
        end else begin
            for (int i = 0; i < l; i++) exp_q.push_back(tb_mem[i]);
        end
        cur_len  = l;
        xfer_cnt = 0;
        start    = 1'b1;
        len      = l[4:0];
        loop_en  = lp;
        tick();
        start    = 1'b0;
        checkOutput("start_valid", {31'd0, out_valid}, 32'd1);
        checkOutput("start_busy", {31'd0, busy}, 32'd1);
        checkOutput("start_word", {16'd0, out_data}, {16'd0, tb_mem[0]});
    endtask

    function automatic logic readyFor(input int mode, input int cyc);
        if (mode == 1) return 1'b1;
        if (mode == 2) return (cyc % 2) == 0;
        return 1'($urandom_range(0, 1));
    endfunction

    // Run a one-shot pass to completion. exact_len > 0 means ready is held
    // high, so done must follow the start by exactly that many cycles.
    task automatic finishPass(input int mode, input int exact_len);
        int cnt;
        cnt = 0;
        while (!done && cnt < 300) begin
            out_ready = readyFor(mode, cnt);
            tick();
            cnt++;
        end
        out_ready = 1'b0;
        checkOutput("done_seen", {31'd0, done}, 32'd1);
        if (exact_len > 0) checkOutput("done_latency", cnt, exact_len);
        checkOutput("busy_in_finish", {31'd0, busy}, 32'd0);
        checkOutput("pass_cnt_once", {16'd0, pass_cnt}, 32'd1);
        checkOutput("queue_drained", exp_q.size(), 32'd0);
        tick();
        checkOutput("done_one_cycle", {31'd0, done}, 32'd0);
        checkOutput("idle_valid", {31'd0, out_valid}, 32'd0);
        checkOutput("idle_data", {16'd0, out_data}, 32'd0);
    endtask

    // Run a looped pass for a number of cycles, then stop. Completed passes
    // are whole multiples of len among transfers made before the stop edge.
    task automatic loopAndStop(input int cycles, input int mode,
                               input logic stop_ready, input int exp_pass);
        for (int c = 0; c < cycles; c++) begin
            out_ready = readyFor(mode, c);
            tick();
        end
        stop      = 1'b1;
        out_ready = stop_ready;
        tick();
        stop      = 1'b0;
        out_ready = 1'b0;
        checkOutput("stop_done", {31'd0, done}, 32'd1);
        checkOutput("stop_busy", {31'd0, busy}, 32'd0);
        checkOutput("stop_pass_cnt", {16'd0, pass_cnt},
                    {16'd0, 16'((xfer_cnt / cur_len) % 65536)});
        if (exp_pass >= 0) checkOutput("stop_pass_fixed", {16'd0, pass_cnt}, exp_pass);
        exp_q.delete();
        tick();
        checkOutput("stop_done_once", {31'd0, done}, 32'd0);
    endtask

    task automatic tryIllegal(input int l);
        start = 1'b1;
        len   = l[4:0];
        tick();
        start = 1'b0;
        for (int c = 0; c < 3; c++) begin
            checkOutput("illegal_quiet", {29'd0, out_valid, busy, done}, 32'd0);
            tick();
        end
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        xfer_cnt  = 0;
        cur_len   = 1;
        rst       = 1'b1;
        wr_en     = 1'b0;
        wr_addr   = '0;
        wr_data   = '0;
        start     = 1'b0;
        stop      = 1'b0;
        len       = '0;
        loop_en   = 1'b0;
        out_ready = 1'b0;
        for (int i = 0; i < 16; i++) tb_mem[i] = 16'h0;
        tick();
        tick();
        checkOutput("reset_outputs", {29'd0, out_valid, busy, done}, 32'd0);
        checkOutput("reset_pass_cnt", {16'd0, pass_cnt}, 32'd0);
        checkOutput("reset_data", {16'd0, out_data}, 32'd0);
        rst = 1'b0;
        tick();

        // Known pattern in every slot, 1..16.
        for (int i = 0; i < 16; i++) writeWord(i, 16'(i + 1));

        $display("[TB] straight pass of 8 words");
        applyStimulus(8, 1'b0);
        finishPass(1, 8);

        $display("[TB] pass of 8 words with alternating ready");
        applyStimulus(8, 1'b0);
        finishPass(2, 0);

        $display("[TB] looped pass of 3 words, stop after 10 cycles");
        applyStimulus(3, 1'b1);
        loopAndStop(10, 1, 1'b0, 3);

        $display("[TB] illegal lengths");
        tryIllegal(0);
        tryIllegal(17);

        $display("[TB] reset in the middle of a pass");
        applyStimulus(8, 1'b0);
        out_ready = 1'b1;
        tick();
        tick();
        tick();
        checkOutput("fourth_word", {16'd0, out_data}, {16'd0, tb_mem[3]});
        rst = 1'b1;
        tick();
        rst       = 1'b0;
        out_ready = 1'b0;
        exp_q.delete();
        checkOutput("reset_abort_valid", {31'd0, out_valid}, 32'd0);
        checkOutput("reset_abort_pass", {16'd0, pass_cnt}, 32'd0);
        checkOutput("reset_abort_done", {31'd0, done}, 32'd0);
        tick();
        checkOutput("reset_no_done", {31'd0, done}, 32'd0);
        applyStimulus(8, 1'b0);
        finishPass(1, 8);

        $display("[TB] write during playback is ignored");
        applyStimulus(8, 1'b0);
        wr_en     = 1'b1;
        wr_addr   = 4'd0;
        wr_data   = 16'hBEEF;
        out_ready = 1'b1;
        tick();
        wr_en = 1'b0;
        finishPass(1, 0);
        applyStimulus(4, 1'b0);
        finishPass(1, 4);
        writeWord(0, 16'hBEEF);
        applyStimulus(4, 1'b0);
        finishPass(1, 4);

        $display("[TB] single word looped and full-depth pass");
        applyStimulus(1, 1'b1);
        loopAndStop(7, 1, 1'b0, 7);
        applyStimulus(16, 1'b0);
        finishPass(1, 16);

        $display("[TB] randomized passes");
        for (int it = 0; it < 10; it++) begin
            for (int w = 0; w < 4; w++) begin
                writeWord(int'($urandom_range(0, 15)), 16'($urandom));
            end
            begin
                int   l;
                logic lp;
                l  = int'($urandom_range(1, 16));
                lp = 1'($urandom_range(0, 1));
                applyStimulus(l, lp);
                if (lp) begin
                    loopAndStop(int'($urandom_range(10, 40)), 0,
                                1'($urandom_range(0, 1)), -1);
                end else begin
                    finishPass(0, 0);
                end
            end
        end

        tick();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
